// File: rtl/i2s_stereo_tx.sv
// i2s_stereo_tx: pops paired left/right samples, rescales and saturates them
// to signed PCM, and serializes each pair as an I2S frame. The system clock
// is divided down to produce bclk and lrclk.
// Optional feature macro: I2S_HOLD_ON_UNDERRUN_EN. When it is defined, an
// underrun frame repeats the previous frame word instead of sending silence.
module i2s_stereo_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAC_SHIFT   = 10,
  parameter int BCLK_DIV     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] left_dout,
  input  logic                  left_empty,
  output logic                  left_rd_en,
  input  logic [DATA_WIDTH-1:0] right_dout,
  input  logic                  right_empty,
  output logic                  right_rd_en,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  frame_done,
  output logic [15:0]           underrun_count
);
  localparam int FW     = 2 * SAMPLE_WIDTH;
  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int SLOT_W = $clog2(FW);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FW - 1);
  localparam logic [SLOT_W-1:0] HALF_LAST = SLOT_W'(SAMPLE_WIDTH - 1);
  localparam logic signed [DATA_WIDTH-1:0] PCM_MAX =
    {{(DATA_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] PCM_MIN =
    {{(DATA_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic [SLOT_W-1:0]   prime_reg, prime_next;
  logic                bclk_reg, bclk_next;
  logic                lrclk_reg, lrclk_next;
  logic                sdata_reg, sdata_next;
  logic                frame_done_reg, frame_done_next;
  logic [FW-1:0]       word_reg, word_next;
  logic [FW-1:0]       shadow_reg, shadow_next;
  logic                shadow_valid_reg, shadow_valid_next;
  logic                pend_reg, pend_next;
  logic [15:0]         underrun_reg, underrun_next;
  logic                pop;
  logic                fall;
  logic                frame_start;
  logic [SLOT_W-1:0]   bit_idx;

  // Arithmetic shift then clamp into the signed PCM range.
  function automatic logic [SAMPLE_WIDTH-1:0] to_pcm(input logic [DATA_WIDTH-1:0] d);
    logic signed [DATA_WIDTH-1:0] s;
    s = $signed(d) >>> FRAC_SHIFT;
    if (s > PCM_MAX) s = PCM_MAX;
    else if (s < PCM_MIN) s = PCM_MIN;
    return s[SAMPLE_WIDTH-1:0];
  endfunction

  // Both FIFOs are popped together; a pending capture blocks a second pop.
  assign pop = (state_reg != IDLE) && !left_empty && !right_empty &&
               !shadow_valid_reg && !pend_reg;
  assign left_rd_en     = pop;
  assign right_rd_en    = pop;
  assign bclk           = bclk_reg;
  assign lrclk          = lrclk_reg;
  assign sdata          = sdata_reg;
  assign frame_done     = frame_done_reg;
  assign underrun_count = underrun_reg;
  assign bit_idx        = SLOT_LAST - slot_reg;

  // Next-state logic: divider, slot sequencing, frame load and shadow refill.
  always_comb begin
    state_next        = state_reg;
    div_next          = div_reg;
    slot_next         = slot_reg;
    prime_next        = prime_reg;
    bclk_next         = bclk_reg;
    lrclk_next        = lrclk_reg;
    sdata_next        = sdata_reg;
    frame_done_next   = 1'b0;
    word_next         = word_reg;
    shadow_next       = shadow_reg;
    shadow_valid_next = shadow_valid_reg;
    pend_next         = pop;
    underrun_next     = underrun_reg;
    fall              = 1'b0;
    frame_start       = 1'b0;

    if (state_reg == IDLE) begin
      if (enable) state_next = PRIME;
    end else begin
      if (div_reg == DIV_LAST) begin
        div_next  = '0;
        bclk_next = ~bclk_reg;
        fall      = bclk_reg;
      end else begin
        div_next = div_reg + DIV_W'(1);
      end
    end

    if (fall) begin
      if (state_reg == PRIME) begin
        if (shadow_valid_reg || prime_reg == SLOT_LAST) frame_start = 1'b1;
        else prime_next = prime_reg + SLOT_W'(1);
      end else if (slot_reg == SLOT_LAST) begin
        frame_start = 1'b1;
      end else begin
        // Entering slot k = slot+1 sends W[FW-k], one bit behind lrclk.
        slot_next  = slot_reg + SLOT_W'(1);
        sdata_next = word_reg[bit_idx];
        lrclk_next = (slot_reg >= HALF_LAST);
      end
    end

    if (frame_start) begin
      frame_done_next = 1'b1;
      prime_next      = '0;
      slot_next       = '0;
      if (!enable) begin
        state_next = IDLE;
        bclk_next  = 1'b0;
        lrclk_next = 1'b0;
        sdata_next = 1'b0;
        div_next   = '0;
      end else begin
        state_next = RUN;
        lrclk_next = 1'b0;
        sdata_next = word_reg[0];
        if (shadow_valid_reg) begin
          word_next         = shadow_reg;
          shadow_valid_next = 1'b0;
        end else begin
`ifdef I2S_HOLD_ON_UNDERRUN_EN
          word_next = word_reg;
`else
          word_next = '0;
`endif
          if (underrun_reg != 16'hFFFF) underrun_next = underrun_reg + 16'd1;
        end
      end
    end

    // Capture lands after any same-cycle load, so new data survives it.
    if (pend_reg) begin
      shadow_next       = {to_pcm(left_dout), to_pcm(right_dout)};
      shadow_valid_next = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      div_reg          <= '0;
      slot_reg         <= '0;
      prime_reg        <= '0;
      bclk_reg         <= 1'b0;
      lrclk_reg        <= 1'b0;
      sdata_reg        <= 1'b0;
      frame_done_reg   <= 1'b0;
      word_reg         <= '0;
      shadow_reg       <= '0;
      shadow_valid_reg <= 1'b0;
      pend_reg         <= 1'b0;
      underrun_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      div_reg          <= div_next;
      slot_reg         <= slot_next;
      prime_reg        <= prime_next;
      bclk_reg         <= bclk_next;
      lrclk_reg        <= lrclk_next;
      sdata_reg        <= sdata_next;
      frame_done_reg   <= frame_done_next;
      word_reg         <= word_next;
      shadow_reg       <= shadow_next;
      shadow_valid_reg <= shadow_valid_next;
      pend_reg         <= pend_next;
      underrun_reg     <= underrun_next;
    end
  end
endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Testbench for i2s_stereo_tx: FIFO model, serial-frame monitor, conversion
// vector table and hand-written sequences for the multi-frame corner cases.
module tb_i2s_stereo_tx;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] left_dout = '0, right_dout = '0;
  logic        left_empty = 1'b1, right_empty = 1'b1;
  logic        left_rd_en, right_rd_en;
  logic        bclk, lrclk, sdata, frame_done;
  logic [15:0] underrun_count;

  i2s_stereo_tx dut (
    .clock(clock), .reset(reset), .enable(enable),
    .left_dout(left_dout), .left_empty(left_empty), .left_rd_en(left_rd_en),
    .right_dout(right_dout), .right_empty(right_empty), .right_rd_en(right_rd_en),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_done(frame_done),
    .underrun_count(underrun_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] w;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] lq [$];
  logic [31:0] rq [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          fd_cyc [16];
  int          nslots [16];
  int          slot_idx = 0;
  int          pops = 0;
  int          pair_err = 0;
  logic        bclk_prev = 1'b0;
  logic [31:0] slots [16];
  logic [31:0] lrs [16];
`ifdef I2S_HOLD_ON_UNDERRUN_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample outputs at negedge, update the FIFO model after posedge.
  task automatic step();
    logic lp;
    @(negedge clock);
    cyc++;
    if (left_rd_en !== right_rd_en) pair_err++;
    lp = left_rd_en;
    if (lp) pops++;
    if (frame_done) begin
      if (fd_cnt < 16) fd_cyc[fd_cnt] = cyc;
      fd_cnt++;
      slot_idx = 0;
    end
    if (bclk && !bclk_prev && fd_cnt > 0 && fd_cnt <= 16 && slot_idx < 32) begin
      slots[fd_cnt-1][31-slot_idx] = sdata;
      lrs[fd_cnt-1][31-slot_idx]   = lrclk;
      slot_idx++;
      nslots[fd_cnt-1] = slot_idx;
    end
    bclk_prev = bclk;
    @(posedge clock);
    #1;
    if (lp && lq.size() > 0 && rq.size() > 0) begin
      left_dout  = lq.pop_front();
      right_dout = rq.pop_front();
    end
    left_empty  = (lq.size() == 0);
    right_empty = (rq.size() == 0);
  endtask

  task automatic clear_mon();
    fd_cnt = 0; slot_idx = 0; pops = 0; pair_err = 0; bclk_prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      slots[i] = '0; lrs[i] = '0; nslots[i] = 0; fd_cyc[i] = 0;
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b0;
    lq.delete(); rq.delete();
    repeat (3) step();
    reset = 1'b1;
    clear_mon();
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      lq.push_back(l); rq.push_back(r);
    end
  endtask

  task automatic wait_fd(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (fd_cnt < n && c < budget) begin
      step();
      c++;
    end
    total++;
    if (fd_cnt < n) begin
      bad++;
      $display("FAIL %s timeout: frame_done count %0d expected %0d", name, fd_cnt, n);
    end
  endtask

  function automatic logic [31:0] word_of(input int f);
    return {slots[f][30:0], slots[f+1][31]};
  endfunction

  initial begin
    vecs[0] = '{l: 32'h0000_0400, r: 32'hFFFF_FC00, w: 32'h0001_FFFF};
    vecs[1] = '{l: 32'h7FFF_FFFF, r: 32'h8000_0000, w: 32'h7FFF_8000};
    vecs[2] = '{l: 32'h0000_0BFF, r: 32'hFFFF_F7FF, w: 32'h0002_FFFD};
    vecs[3] = '{l: 32'h01FF_FC00, r: 32'hFE00_0400, w: 32'h7FFF_8001};
    vecs[4] = '{l: 32'h0200_0000, r: 32'hFDFF_FC00, w: 32'h7FFF_8000};
    vecs[5] = '{l: 32'h1234_5678, r: 32'h00AB_CD00, w: 32'h7FFF_2AF3};

    // Reset state, then IDLE must not pop even with data waiting.
    repeat (2) step();
    check("reset_outputs", {26'd0, bclk, lrclk, sdata, frame_done, left_rd_en, right_rd_en}, 32'd0);
    check("reset_underrun", {16'd0, underrun_count}, 32'd0);
    push(32'h400, 32'h400, 1);
    reset = 1'b1;
    clear_mon();
    repeat (20) step();
    check("idle_no_pop", pops, 0);
    check("idle_bclk", {31'd0, bclk}, 32'd0);
    $display("seq reset/idle: pops=%0d", pops);

    // Conversion vectors: one pair each, real frame then underrun frames.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      push(vecs[v].l, vecs[v].r, 1);
      enable = 1'b1;
      wait_fd(3, 1000, "vec_frames");
      check($sformatf("vec%0d_word", v), word_of(0), vecs[v].w);
      check($sformatf("vec%0d_lrclk", v), lrs[0], 32'h0000_FFFF);
      check($sformatf("vec%0d_pops", v), pops, 1);
      check($sformatf("vec%0d_period", v), fd_cyc[1] - fd_cyc[0], 256);
      check($sformatf("vec%0d_underrun", v), {16'd0, underrun_count}, 32'd2);
      check($sformatf("vec%0d_pair", v), pair_err, 0);
      $display("vec %0d: L=%h R=%h W=%h", v, vecs[v].l, vecs[v].r, word_of(0));
    end

    // Sustained underrun after one real frame.
    do_reset();
    push(32'h0000_0400, 32'hFFFF_FC00, 1);
    enable = 1'b1;
    wait_fd(4, 1400, "underrun_frames");
    repeat (8) step();
    check("sus_underrun_count", {16'd0, underrun_count}, 32'd3);
    check("sus_period_a", fd_cyc[2] - fd_cyc[1], 256);
    check("sus_period_b", fd_cyc[3] - fd_cyc[2], 256);
    check("sus_fd_count", fd_cnt, 4);
    check("sus_word0", word_of(0), 32'h0001_FFFF);
    check("sus_word1", word_of(1), HOLD ? 32'h0001_FFFF : 32'h0);
    check("sus_word2", word_of(2), HOLD ? 32'h0001_FFFF : 32'h0);
    $display("seq sustained underrun: count=%0d W1=%h", underrun_count, word_of(1));

    // Asymmetric FIFOs: left only, then right arrives.
    do_reset();
    lq.push_back(32'h0000_0400);
    enable = 1'b1;
    wait_fd(1, 600, "asym_first");
    check("asym_underrun1", {16'd0, underrun_count}, 32'd1);
    repeat (20) step();
    check("asym_no_pop", pops, 0);
    rq.push_back(32'hFFFF_FC00);
    wait_fd(3, 800, "asym_frames");
    repeat (8) step();
    check("asym_one_pop", pops, 1);
    check("asym_word0", word_of(0), 32'h0);
    check("asym_word1", word_of(1), 32'h0001_FFFF);
    check("asym_underrun2", {16'd0, underrun_count}, 32'd2);
    check("asym_pair", pair_err, 0);
    $display("seq asymmetric: pops=%0d W1=%h", pops, word_of(1));

    // Enable drop at slot 10: frame finishes, then IDLE.
    do_reset();
    push(32'h0000_0400, 32'hFFFF_FC00, 4);
    enable = 1'b1;
    wait_fd(1, 100, "drop_first");
    repeat (80) step();
    enable = 1'b0;
    wait_fd(2, 400, "drop_end");
    check("drop_slots", nslots[0], 32);
    check("drop_period", fd_cyc[1] - fd_cyc[0], 256);
    begin
      int idle_bad;
      idle_bad = 0;
      pops = 0;
      for (int i = 0; i < 60; i++) begin
        step();
        if (bclk || lrclk || sdata) idle_bad++;
      end
      check("drop_idle_lines", idle_bad, 0);
      check("drop_idle_pops", pops, 0);
      $display("seq enable drop: slots=%0d idle_bad=%0d", nslots[0], idle_bad);
    end

    // Reset asserted at slot 20 of a frame.
    do_reset();
    enable = 1'b1;
    wait_fd(1, 600, "rst_first");
    check("rst_pre_underrun", {16'd0, underrun_count}, 32'd1);
    push(32'h0000_0400, 32'hFFFF_FC00, 4);
    repeat (160) step();
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_lines", {27'd0, bclk, lrclk, sdata, frame_done, left_rd_en}, 32'd0);
    check("rst_async_underrun", {16'd0, underrun_count}, 32'd0);
    repeat (3) step();
    reset = 1'b1;
    clear_mon();
    wait_fd(1, 100, "rst_restart");
    check("rst_restart_underrun", {16'd0, underrun_count}, 32'd0);
    wait_fd(2, 400, "rst_second");
    repeat (8) step();
    check("rst_word0", word_of(0), 32'h0001_FFFF);
    check("rst_lrclk0", lrs[0], 32'h0000_FFFF);
    check("rst_underrun_end", {16'd0, underrun_count}, 32'd0);
    $display("seq reset mid-frame: W0=%h underrun=%0d", word_of(0), underrun_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_stereo_tx.md
Name: i2s_stereo_tx

Overview:
- Audio output stage downstream of the left/right output FIFOs of the FM stereo receiver.
- Pops one left and one right sample together, so channels stay locked.
- Rescales each sample from the fixed-point pipeline format to a saturated signed PCM word.
- Serializes each pair as a standard I2S frame, generating the bit clock (bclk) and word-select clock (lrclk) from the system clock.

Parameters:
- DATA_WIDTH, 32, width of FIFO sample words.
- SAMPLE_WIDTH, 16, PCM bits per channel. One frame is 2*SAMPLE_WIDTH bit slots.
- FRAC_SHIFT, 10, arithmetic right shift applied before saturation (matches the 10-bit quantization).
- BCLK_DIV, 4, system clocks per bclk half-period. Minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start/continue framing.
- left_dout  in  DATA_WIDTH  left FIFO read data.
- left_empty  in  1  left FIFO empty.
- left_rd_en  out  1  left FIFO pop.
- right_dout  in  DATA_WIDTH  right FIFO read data.
- right_empty  in  1  right FIFO empty.
- right_rd_en  out  1  right FIFO pop.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  word select: 0 = left, 1 = right.
- sdata  out  1  serial data, MSB first.
- frame_done  out  1  one-cycle pulse at each frame boundary.
- underrun_count  out  16  frames sent without fresh data; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0, shadow invalid, state IDLE, previous-word register 0.
- FIFO read timing: dout is valid the cycle after rd_en.
- Pop rule:
  - left_rd_en and right_rd_en are always identical.
  - Asserted for one cycle only when !left_empty && !right_empty && shadow invalid && state != IDLE.
  - Never pop one FIFO without the other.
- Capture: in the cycle after a pop, both douts are converted and written to the shadow register; shadow becomes valid.
- Conversion per channel:
  - s = dout >>> FRAC_SHIFT (signed).
  - Clamp s to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - Frame word W = {L_pcm, R_pcm}, left in the MSBs.
- Clock divider:
  - Counter 0..BCLK_DIV-1. bclk toggles when the counter wraps.
  - sdata and lrclk change only at bclk falling edges, so they are stable while bclk is high.
  - Bit slot = 2*BCLK_DIV clocks. Frame = 2*SAMPLE_WIDTH slots (32 slots = 256 clocks at defaults).
- States:
  - IDLE: bclk, lrclk, sdata held 0; divider held. When enable=1, go to PRIME.
  - PRIME: wait until the shadow is valid or 2*SAMPLE_WIDTH bit periods elapse, then go to RUN at slot 0.
  - RUN: slot counter 0..2*SAMPLE_WIDTH-1.
- At the falling edge entering slot 0:
  - Shadow valid: W loads from the shadow; shadow invalid.
  - Shadow invalid (underrun): W = 0 and underrun_count increments by 1 (saturating).
  - frame_done pulses for one cycle.
  - If enable=0 at this edge, go to IDLE instead; the final frame has already been fully transmitted.
- I2S one-bit delay:
  - lrclk = 0 for slots 0..SAMPLE_WIDTH-1, 1 otherwise.
  - sdata in slot 0 = bit 0 of the previous W.
  - sdata in slot k (1..31 at defaults) = W[2*SAMPLE_WIDTH-k].
- Shadow refill: may occur any time during the frame. A pop never overwrites a valid shadow.
- Reset mid-frame: immediate return to reset state. A popped pair not yet latched is discarded.
- Simultaneous events: a pop in the same cycle as the slot-0 load is allowed. The load consumes the old shadow first; the new data lands on the next cycle.

Optional Feature:
- Macro: I2S_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, W reloads the previous frame word instead of 0. underrun_count still increments.
- Undefined: underrun frames are all-zero.

Test Plan:
- Unity sample: left=0x00000400, right=0xFFFFFC00.
  - W=0x0001FFFF.
  - sdata slots 1..16 = 0x0001 MSB-first; slots 17..31 plus next slot 0 = 0xFFFF.
  - lrclk low for slots 0..15; exactly one pop per frame.
- Saturation: left=0x7FFFFFFF, right=0x80000000 -> L_pcm=0x7FFF, R_pcm=0x8000.
- Asymmetric FIFOs: left non-empty, right empty.
  - No rd_en asserted.
  - Next frame is all zeros; underrun_count goes 0 -> 1.
  - Filling right afterwards produces exactly one paired pop.
- Sustained underrun: both FIFOs empty for 3 frames.
  - underrun_count = 3.
  - frame_done pulses 3 times, 256 clocks apart.
  - With I2S_HOLD_ON_UNDERRUN_EN, sdata repeats the last real W.
- Enable drop mid-frame (slot 10): frame completes through slot 31, then IDLE with bclk/lrclk/sdata = 0 and no further pops.
- Reset asserted at slot 20: all outputs 0 asynchronously, within the same cycle. After release with enable=1, the first frame starts from PRIME with slot 0 and underrun_count = 0.
